// File: rtl/seq_mul_pkg.sv
// Shared types for the sequential shift-add multiplier.
package seq_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : seq_mul_pkg

// File: rtl/seq_mul_if.sv
// Operand/product valid-ready bus for seq_mul; master feeds operands and drains products.
interface seq_mul_if #(
   parameter int WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_a;
   logic [WIDTH-1:0]     in_b;
   logic                 in_signed;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_p;

   modport master (
      output in_valid, in_a, in_b, in_signed, out_ready,
      input  in_ready, out_valid, out_p
   );

   modport slave (
      input  in_valid, in_a, in_b, in_signed, out_ready,
      output in_ready, out_valid, out_p
   );
endinterface : seq_mul_if

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: one multiplier bit per clock through a single adder,
// unsigned or two's-complement per transaction, valid/ready on both sides.
module seq_mul
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic     clk,
   input  logic     rst_n,
   seq_mul_if.slave bus
);

   localparam int CW = $clog2(WIDTH);
   localparam int PW = 2 * WIDTH;

   state_t            state;
   logic [WIDTH-1:0]  mcand;
   logic [WIDTH-1:0]  mplier;
   logic              neg;
   logic [PW-1:0]     acc;
   logic [CW-1:0]     cnt;
   logic [PW-1:0]     p_q;

   logic              a_neg;
   logic              b_neg;
   logic [WIDTH-1:0]  a_mag;
   logic [WIDTH-1:0]  b_mag;
   logic [PW-1:0]     addend;
   logic [PW-1:0]     sum;

   // Magnitudes fit in WIDTH bits unsigned, including -2^(WIDTH-1).
   always_comb begin
      a_neg  = bus.in_signed & bus.in_a[WIDTH-1];
      b_neg  = bus.in_signed & bus.in_b[WIDTH-1];
      a_mag  = a_neg ? -bus.in_a : bus.in_a;
      b_mag  = b_neg ? -bus.in_b : bus.in_b;
      addend = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
      sum    = acc + addend;
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out_p     = p_q;

   // NOTE: all state, including the datapath registers, is reset so an aborted
   // transaction leaves nothing behind; sequential state uses <= only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         neg    <= 1'b0;
         acc    <= '0;
         cnt    <= '0;
         p_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  mcand  <= a_mag;
                  mplier <= b_mag;
                  neg    <= a_neg ^ b_neg;
                  acc    <= '0;
                  cnt    <= '0;
                  state  <= CALC;
               end
            end
            CALC: begin
               acc    <= sum;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  p_q   <= neg ? -sum : sum;
                  state <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule : seq_mul

// File: tb/tb_seq_mul.sv
// Directed self-checking bench for seq_mul at WIDTH=8 and a full WIDTH=4 sweep.
module tb_seq_mul;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   seq_mul_if #(.WIDTH(8)) i8 ();
   seq_mul_if #(.WIDTH(4)) i4 ();

   seq_mul #(.WIDTH(8)) u_mul8 (.clk(clk), .rst_n(rst_n), .bus(i8));
   seq_mul #(.WIDTH(4)) u_mul4 (.clk(clk), .rst_n(rst_n), .bus(i4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Accepts one pair on the next edge, then counts edges until out_valid (bounded).
   task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input bit jitter, output logic [15:0] p, output int lat,
                       output bit busy_ok);
      i8.in_a      = a;
      i8.in_b      = b;
      i8.in_signed = s;
      i8.in_valid  = 1'b1;
      @(posedge clk);
      #1;
      i8.in_valid = 1'b0;
      lat     = 0;
      busy_ok = 1'b1;
      while (!i8.out_valid && lat < 20) begin
         if (i8.in_ready) busy_ok = 1'b0;
         if (jitter) begin
            i8.in_a      = 8'($urandom);
            i8.in_b      = 8'($urandom);
            i8.in_signed = 1'($urandom);
         end
         @(posedge clk);
         #1;
         lat++;
      end
      p = i8.out_p;
   endtask

   task automatic consume8();
      i8.out_ready = 1'b1;
      @(posedge clk);
      #1;
      i8.out_ready = 1'b0;
   endtask

   task automatic mul4(input logic [3:0] a, input logic [3:0] b, input logic s,
                       output logic [7:0] p, output int lat);
      i4.in_a      = a;
      i4.in_b      = b;
      i4.in_signed = s;
      i4.in_valid  = 1'b1;
      @(posedge clk);
      #1;
      i4.in_valid = 1'b0;
      lat = 0;
      while (!i4.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      p = i4.out_p;
      i4.out_ready = 1'b1;
      @(posedge clk);
      #1;
      i4.out_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] p8;
      logic [15:0] held;
      logic [7:0]  p4;
      logic [31:0] ref4;
      int          lat;
      int          sa;
      int          sb;
      bit          busy_ok;
      bit          bp_ok;
      bit          lat4_ok;

      n_cmp = 0;
      n_err = 0;
      i8.in_valid = 1'b0; i8.in_a = '0; i8.in_b = '0; i8.in_signed = 1'b0; i8.out_ready = 1'b0;
      i4.in_valid = 1'b0; i4.in_a = '0; i4.in_b = '0; i4.in_signed = 1'b0; i4.out_ready = 1'b0;

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready", 32'(i8.in_ready), 32'd1);
      check("reset out_valid", 32'(i8.out_valid), 32'd0);
      check("reset out_p", 32'(i8.out_p), 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Unsigned corner with latency and busy check
      mul8(8'hFF, 8'hFF, 1'b0, 1'b0, p8, lat, busy_ok);
      check("u 255x255", 32'(p8), 32'hFE01);
      check("u 255x255 latency", 32'(lat), 32'd8);
      check("u 255x255 in_ready low in CALC", 32'(busy_ok), 32'd1);
      check("DONE in_ready low", 32'(i8.in_ready), 32'd0);
      consume8();
      check("after consume out_valid", 32'(i8.out_valid), 32'd0);

      // Signed vectors and the unsigned reading of the same bits
      mul8(8'hFD, 8'h05, 1'b1, 1'b0, p8, lat, busy_ok);
      check("s -3x5", 32'(p8), 32'hFFF1);
      consume8();
      mul8(8'h80, 8'h80, 1'b1, 1'b0, p8, lat, busy_ok);
      check("s -128x-128", 32'(p8), 32'h4000);
      consume8();
      mul8(8'h80, 8'h7F, 1'b1, 1'b0, p8, lat, busy_ok);
      check("s -128x127", 32'(p8), 32'hC080);
      consume8();
      mul8(8'hFD, 8'h05, 1'b0, 1'b0, p8, lat, busy_ok);
      check("u 0xFDx0x05", 32'(p8), 32'h04F1);
      consume8();

      // Backpressure: product held, then a one-cycle handshake with no overlapped accept
      mul8(8'h12, 8'h34, 1'b0, 1'b0, p8, lat, busy_ok);
      check("bp product", 32'(p8), 32'h03A8);
      held  = p8;
      bp_ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (i8.out_p !== held || i8.in_ready !== 1'b0 || i8.out_valid !== 1'b1) bp_ok = 1'b0;
      end
      check("bp held stable", 32'(bp_ok), 32'd1);
      i8.in_a = 8'h11; i8.in_b = 8'h22; i8.in_signed = 1'b0;
      i8.in_valid  = 1'b1;
      i8.out_ready = 1'b1;
      @(posedge clk);
      #1;
      i8.out_ready = 1'b0;
      check("bp release out_valid", 32'(i8.out_valid), 32'd0);
      check("no accept on consume edge", 32'(i8.in_ready), 32'd1);
      i8.in_valid = 1'b0;

      // Operands toggled during CALC are ignored
      mul8(8'h5A, 8'h3C, 1'b0, 1'b1, p8, lat, busy_ok);
      check("jitter u 0x5Ax0x3C", 32'(p8), 32'h1518);
      consume8();
      mul8(8'h9C, 8'h07, 1'b1, 1'b1, p8, lat, busy_ok);
      check("jitter s -100x7", 32'(p8), 32'hFD44);
      consume8();

      // Reset pulsed with counter = 3
      i8.in_a = 8'hFF; i8.in_b = 8'hFF; i8.in_signed = 1'b0;
      i8.in_valid = 1'b1;
      @(posedge clk);
      #1;
      i8.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid-CALC reset out_valid", 32'(i8.out_valid), 32'd0);
      check("mid-CALC reset out_p", 32'(i8.out_p), 32'h0);
      check("mid-CALC reset in_ready", 32'(i8.in_ready), 32'd1);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mul8(8'd7, 8'd6, 1'b0, 1'b0, p8, lat, busy_ok);
      check("post-reset 7x6", 32'(p8), 32'h002A);
      check("post-reset latency", 32'(lat), 32'd8);
      consume8();

      // WIDTH=4 exhaustive sweep, unsigned then signed
      lat4_ok = 1'b1;
      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               sa = (s == 1 && a > 7) ? a - 16 : a;
               sb = (s == 1 && b > 7) ? b - 16 : b;
               ref4 = 32'(sa * sb);
               mul4(4'(a), 4'(b), 1'(s), p4, lat);
               if (lat != 4) lat4_ok = 1'b0;
               check($sformatf("w4 s=%0d %0d*%0d", s, a, b), 32'(p4), 32'(ref4[7:0]));
            end
         end
      end
      check("w4 latency", 32'(lat4_ok), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_seq_mul
